// File: rtl/pipeline_rb_subtractor.sv
// Three-stage pipelined ripple-borrow subtractor: diff = a - b - bin, bout = final borrow.
// Segments resolve bits [SEG1-1:0], [SEG2-1:SEG1] and [WIDTH-1:SEG2] in stages 1..3.
// A valid/ready handshake with full backpressure lets empty stages collapse while the output is stalled.
module pipeline_rb_subtractor #(
  parameter int WIDTH = 64,
  parameter int SEG1  = 23,
  parameter int SEG2  = 46
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Stage 1 registers
  logic                  v1;
  logic [WIDTH-1:SEG1]   a1_hi;
  logic [WIDTH-1:SEG1]   b1_hi;
  logic [SEG1-1:0]       d1;
  logic                  br1;

  // Stage 2 registers
  logic                  v2;
  logic [WIDTH-1:SEG2]   a2_hi;
  logic [WIDTH-1:SEG2]   b2_hi;
  logic [SEG2-1:0]       d2;
  logic                  br2;

  // Combinational segment results
  logic [SEG1-1:0]       s1_diff;
  logic                  s1_br;
  logic [SEG2-1:0]       s2_diff;
  logic                  s2_br;
  logic [WIDTH-1:0]      s3_diff;
  logic                  s3_br;

  // Advance enables
  logic adv1;
  logic adv2;
  logic adv3;

  assign adv3     = ~out_valid | out_ready;
  assign adv2     = ~v2 | adv3;
  assign adv1     = ~v1 | adv2;
  assign in_ready = adv1;

  // Ripple the borrow through the low segment, starting from the external borrow in.
  always_comb begin : seg1_ripple
    logic br;
    br      = bin;
    s1_diff = '0;
    for (int i = 0; i < SEG1; i++) begin
      s1_diff[i] = a[i] ^ b[i] ^ br;
      br         = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    s1_br = br;
  end

  // Ripple the middle segment from the borrow captured in stage 1.
  always_comb begin : seg2_ripple
    logic br;
    br      = br1;
    s2_diff = '0;
    s2_diff[SEG1-1:0] = d1;
    for (int i = SEG1; i < SEG2; i++) begin
      s2_diff[i] = a1_hi[i] ^ b1_hi[i] ^ br;
      br         = (~a1_hi[i] & b1_hi[i]) | (~(a1_hi[i] ^ b1_hi[i]) & br);
    end
    s2_br = br;
  end

  // Ripple the top segment from the borrow captured in stage 2.
  always_comb begin : seg3_ripple
    logic br;
    br      = br2;
    s3_diff = '0;
    s3_diff[SEG2-1:0] = d2;
    for (int i = SEG2; i < WIDTH; i++) begin
      s3_diff[i] = a2_hi[i] ^ b2_hi[i] ^ br;
      br         = (~a2_hi[i] & b2_hi[i]) | (~(a2_hi[i] ^ b2_hi[i]) & br);
    end
    s3_br = br;
  end

  // Stage 1: capture the low-segment result; data only moves when a real operation advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      a1_hi <= '0;
      b1_hi <= '0;
      d1    <= '0;
      br1   <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1_hi <= a[WIDTH-1:SEG1];
        b1_hi <= b[WIDTH-1:SEG1];
        d1    <= s1_diff;
        br1   <= s1_br;
      end
    end
  end

  // Stage 2: capture the middle-segment result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      a2_hi <= '0;
      b2_hi <= '0;
      d2    <= '0;
      br2   <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        a2_hi <= a1_hi[WIDTH-1:SEG2];
        b2_hi <= b1_hi[WIDTH-1:SEG2];
        d2    <= s2_diff;
        br2   <= s2_br;
      end
    end
  end

  // Stage 3: output register, held stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
    end else if (adv3) begin
      out_valid <= v2;
      if (v2) begin
        diff <= s3_diff;
        bout <= s3_br;
      end
    end
  end

endmodule
